// File: rtl/balancer_n_pkg.sv
// Shared definitions for the N-channel belt balancer.
//   SAMPLE_W  : sample / window-sum width (signed two's complement)
//   MAX_N     : largest supported channel count
//   state_t   : divert state machine encoding (IDLE=0, DIVERT=1)
//   onehot    : index -> one-hot vector (bits at or above n forced to 0)
//   sat_add32 : saturating signed add, only used when BALANCER_N_SATURATE_EN
//               is defined
package balancer_pkg;

    localparam int unsigned SAMPLE_W = 32;
    localparam int unsigned MAX_N    = 16;

    localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 32'sh8000_0000;

    typedef enum logic {
        IDLE   = 1'b0,
        DIVERT = 1'b1
    } state_t;

    function automatic logic [MAX_N-1:0] onehot(input int unsigned idx,
                                                input int unsigned n);
        logic [MAX_N-1:0] r;
        r = '0;
        for (int unsigned k = 0; k < MAX_N; k++) begin
            if (k == idx && k < n) begin
                r[k] = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic signed [SAMPLE_W-1:0] sat_add32(
        input logic signed [SAMPLE_W-1:0] a,
        input logic signed [SAMPLE_W-1:0] b
    );
        logic [SAMPLE_W:0] s;
        s = {a[SAMPLE_W-1], a} + {b[SAMPLE_W-1], b};
        // The two top bits disagree only when the true result left 32-bit range.
        if (s[SAMPLE_W] != s[SAMPLE_W-1]) begin
            return s[SAMPLE_W] ? SAT_MIN : SAT_MAX;
        end
        return s[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/balancer_n_if.sv
// Sample/control bus of balancer_n.
//   in_valid   : new sample set strobe          (master -> slave)
//   in_data    : N packed signed 32-bit samples (master -> slave)
//   threshold  : signed imbalance threshold     (master -> slave)
//   warm       : window filled                  (slave -> master)
//   active     : divert in progress             (slave -> master)
//   divert_src : one-hot busiest channel        (slave -> master)
//   divert_dst : one-hot idlest channel         (slave -> master)
//   sum_out    : N packed window sums           (slave -> master)
interface balancer_n_if #(parameter int unsigned N = 4);
    import balancer_pkg::*;

    logic                       in_valid;
    logic [N*SAMPLE_W-1:0]      in_data;
    logic signed [SAMPLE_W-1:0] threshold;
    logic                       warm;
    logic                       active;
    logic [N-1:0]               divert_src;
    logic [N-1:0]               divert_dst;
    logic [N*SAMPLE_W-1:0]      sum_out;

    modport master (
        output in_valid, in_data, threshold,
        input  warm, active, divert_src, divert_dst, sum_out
    );

    modport slave (
        input  in_valid, in_data, threshold,
        output warm, active, divert_src, divert_dst, sum_out
    );

endinterface

// File: rtl/balancer_n_rolling_window_sum.sv
// One channel's rolling window: DEPTH-entry ring buffer plus running sum.
//   clk, rst : clock, synchronous active-high reset
//   in_valid : accept sample into slot wr_ptr
//   wr_ptr   : shared write pointer (slot holding the oldest sample)
//   sample   : new signed sample
//   sum      : registered sum of the last DEPTH samples
// With BALANCER_N_SATURATE_EN defined the sum clamps to the 32-bit range
// instead of wrapping; ring contents always stay exact.
module rolling_window_sum #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned SAMPLE_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [$clog2(DEPTH)-1:0]   wr_ptr,
    input  logic signed [SAMPLE_W-1:0] sample,
    output logic signed [SAMPLE_W-1:0] sum
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic signed [SAMPLE_W-1:0] ring [DEPTH];
    logic signed [SAMPLE_W-1:0] oldest;
    logic signed [SAMPLE_W-1:0] sum_next;

    assign oldest = ring[wr_ptr];

`ifdef BALANCER_N_SATURATE_EN
    localparam int unsigned WIDE_W = SAMPLE_W + PTR_W + 1;
    localparam logic signed [WIDE_W-1:0] MAXW = WIDE_W'({1'b0, {(SAMPLE_W-1){1'b1}}});
    localparam logic signed [WIDE_W-1:0] MINW = ~MAXW;

    logic signed [WIDE_W-1:0] inc_wide;
    logic signed [WIDE_W-1:0] total_wide;
    logic signed [WIDE_W-1:0] pick_wide;
    logic                     sat_q;
    logic                     sat_next;

    // While the stored sum is clipped it no longer equals the ring total, so
    // the exact total is rebuilt from the ring until it is back in range.
    always_comb begin
        inc_wide   = WIDE_W'(sum) + WIDE_W'(sample) - WIDE_W'(oldest);
        total_wide = WIDE_W'(sample);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (PTR_W'(i) != wr_ptr) begin
                total_wide = total_wide + WIDE_W'(ring[i]);
            end
        end
        pick_wide = (sat_q || inc_wide > MAXW || inc_wide < MINW) ? total_wide : inc_wide;
        sat_next  = (pick_wide > MAXW) || (pick_wide < MINW);
        if (pick_wide > MAXW) begin
            sum_next = MAXW[SAMPLE_W-1:0];
        end else if (pick_wide < MINW) begin
            sum_next = MINW[SAMPLE_W-1:0];
        end else begin
            sum_next = pick_wide[SAMPLE_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else if (in_valid) begin
            sat_q <= sat_next;
        end
    end
`else
    always_comb begin
        sum_next = sum + sample - oldest;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ring[i] <= '0;
            end
            sum <= '0;
        end else if (in_valid) begin
            ring[wr_ptr] <= sample;
            sum          <= sum_next;
        end
    end

endmodule

// File: rtl/balancer_n.sv
// N-channel belt balancer: rolling window sums per channel, busiest/idlest
// detection, and a hysteresis FSM issuing a latched one-hot divert request.
//   clk, rst : clock, synchronous active-high reset
//   bus      : balancer_n_if.slave (in_valid, in_data, threshold in;
//              warm, active, divert_src, divert_dst, sum_out out)
// Optional build macro BALANCER_N_SATURATE_EN: saturating sums and
// threshold arithmetic instead of wrap-around.
module balancer_n
    import balancer_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned HOLD  = 4,
    parameter int          HYST  = 2
) (
    input  logic          clk,
    input  logic          rst,
    balancer_n_if.slave   bus
);

    localparam int unsigned IDX_W  = $clog2(N);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned FILL_W = $clog2(DEPTH + 1);
    localparam int unsigned HOLD_W = $clog2(HOLD + 1);
    localparam logic signed [SAMPLE_W-1:0] HYST_S = SAMPLE_W'(HYST);

    logic [PTR_W-1:0]           wr_ptr;
    logic [FILL_W-1:0]          fill;
    logic                       warm_q;
    logic signed [SAMPLE_W-1:0] sums [N];

    // ---------------- stage 1: window sums ----------------
    for (genvar k = 0; k < N; k++) begin : g_ch
        rolling_window_sum #(
            .DEPTH   (DEPTH),
            .SAMPLE_W(SAMPLE_W)
        ) u_win (
            .clk     (clk),
            .rst     (rst),
            .in_valid(bus.in_valid),
            .wr_ptr  (wr_ptr),
            .sample  (bus.in_data[SAMPLE_W*k +: SAMPLE_W]),
            .sum     (sums[k])
        );
    end

    always_comb begin
        for (int unsigned k = 0; k < N; k++) begin
            bus.sum_out[SAMPLE_W*k +: SAMPLE_W] = sums[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            fill   <= '0;
            warm_q <= 1'b0;
        end else if (bus.in_valid) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            if (fill != FILL_W'(DEPTH)) begin
                fill <= fill + FILL_W'(1);
            end
            if (fill == FILL_W'(DEPTH - 1)) begin
                warm_q <= 1'b1;
            end
        end
    end

    assign bus.warm = warm_q;

    // ---------------- stage 2: busiest / idlest ----------------
    logic [IDX_W-1:0]           max_idx_c, min_idx_c, max_idx, min_idx;
    logic signed [SAMPLE_W-1:0] max_sum_c, min_sum_c, max_sum, min_sum;
    logic                       warm_s2;

    // Strict comparisons keep the lowest index on ties.
    always_comb begin
        max_idx_c = '0;
        min_idx_c = '0;
        max_sum_c = sums[0];
        min_sum_c = sums[0];
        for (int unsigned k = 1; k < N; k++) begin
            if (sums[k] > max_sum_c) begin
                max_sum_c = sums[k];
                max_idx_c = IDX_W'(k);
            end
            if (sums[k] < min_sum_c) begin
                min_sum_c = sums[k];
                min_idx_c = IDX_W'(k);
            end
        end
    end

    // warm travels with the stage-2 data so the FSM only ever sees extremes
    // computed from a full window.
    always_ff @(posedge clk) begin
        if (rst) begin
            max_idx <= '0;
            min_idx <= '0;
            max_sum <= '0;
            min_sum <= '0;
            warm_s2 <= 1'b0;
        end else begin
            max_idx <= max_idx_c;
            min_idx <= min_idx_c;
            max_sum <= max_sum_c;
            min_sum <= min_sum_c;
            warm_s2 <= warm_q;
        end
    end

    // ---------------- divert FSM ----------------
    state_t                     state_q, state_d;
    logic [HOLD_W-1:0]          hold_q, hold_d;
    logic [IDX_W-1:0]           src_q, src_d, dst_q, dst_d;
    logic signed [SAMPLE_W-1:0] entry_rhs, exit_rhs;

`ifdef BALANCER_N_SATURATE_EN
    localparam logic signed [SAMPLE_W-1:0] NEG_HYST = -HYST_S;
    assign entry_rhs = sat_add32(min_sum, bus.threshold);
    assign exit_rhs  = sat_add32(sat_add32(sums[dst_q], bus.threshold), NEG_HYST);
`else
    assign entry_rhs = min_sum + bus.threshold;
    assign exit_rhs  = sums[dst_q] + bus.threshold - HYST_S;
`endif

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        src_d   = src_q;
        dst_d   = dst_q;
        unique case (state_q)
            IDLE: begin
                if (warm_s2 && max_idx != min_idx && max_sum > entry_rhs) begin
                    state_d = DIVERT;
                    hold_d  = HOLD_W'(HOLD);
                    src_d   = max_idx;
                    dst_d   = min_idx;
                end
            end
            DIVERT: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - HOLD_W'(1);
                end else if (sums[src_q] <= exit_rhs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            src_q   <= '0;
            dst_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
        end
    end

    // Output register stage driven from the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.active     <= 1'b0;
            bus.divert_src <= '0;
            bus.divert_dst <= '0;
        end else begin
            bus.active     <= (state_q == DIVERT);
            bus.divert_src <= (state_q == DIVERT) ? N'(onehot(32'(src_q), N)) : '0;
            bus.divert_dst <= (state_q == DIVERT) ? N'(onehot(32'(dst_q), N)) : '0;
        end
    end

endmodule

// File: tb/tb_balancer_n.sv
module tb_balancer_n;

    localparam int unsigned N     = 4;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned HOLD  = 4;
    localparam int          HYST  = 2;

`ifdef BALANCER_N_SATURATE_EN
    localparam logic [31:0] EXP_OVF2 = 32'h7FFF_FFFF;
    localparam logic [31:0] EXP_OVF8 = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] EXP_OVF2 = 32'h8000_0000;
    localparam logic [31:0] EXP_OVF8 = 32'h0000_0000;
`endif

    logic clk = 1'b0;
    logic rst;
    logic cmp_en = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    balancer_n_if #(.N(N)) bus ();

    balancer_n #(.N(N), .DEPTH(DEPTH), .HOLD(HOLD), .HYST(HYST)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic signed [31:0] hist [N][$];
    logic signed [31:0] m_sum [N];
    int                 m_cnt;
    logic               m_warm;
    int                 s2_maxi, s2_mini;
    logic signed [31:0] s2_max, s2_min;
    logic               s2_warm;
    logic               m_div;
    int                 m_src, m_dst, m_age;
    logic               m_active;
    logic [N-1:0]       m_src_oh, m_dst_oh;

    function automatic logic signed [31:0] fit(input longint v);
`ifdef BALANCER_N_SATURATE_EN
        if (v > 64'sd2147483647)  return 32'sh7FFF_FFFF;
        if (v < -64'sd2147483648) return 32'sh8000_0000;
`endif
        return v[31:0];
    endfunction

    // Evaluated newest-stage-last so every stage sees pre-edge values.
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                hist[k].delete();
                m_sum[k] = '0;
            end
            m_cnt = 0; m_warm = 0;
            s2_maxi = 0; s2_mini = 0; s2_max = '0; s2_min = '0; s2_warm = 0;
            m_div = 0; m_src = 0; m_dst = 0; m_age = 0;
            m_active = 0; m_src_oh = '0; m_dst_oh = '0;
        end else begin
            m_active = m_div;
            m_src_oh = m_div ? (N'(1) << m_src) : '0;
            m_dst_oh = m_div ? (N'(1) << m_dst) : '0;
            if (!m_div) begin
                if (s2_warm && s2_maxi != s2_mini &&
                    s2_max > fit(longint'(s2_min) + longint'(bus.threshold))) begin
                    m_div = 1; m_src = s2_maxi; m_dst = s2_mini; m_age = 0;
                end
            end else if (m_age >= HOLD &&
                         m_sum[m_src] <= fit(longint'(fit(longint'(m_sum[m_dst]) +
                                             longint'(bus.threshold))) - longint'(HYST))) begin
                m_div = 0;
            end else if (m_age < HOLD) begin
                m_age++;
            end
            s2_maxi = 0; s2_mini = 0;
            for (int k = 1; k < N; k++) begin
                if (m_sum[k] > m_sum[s2_maxi]) s2_maxi = k;
                if (m_sum[k] < m_sum[s2_mini]) s2_mini = k;
            end
            s2_max = m_sum[s2_maxi]; s2_min = m_sum[s2_mini]; s2_warm = m_warm;
            if (bus.in_valid) begin
                for (int k = 0; k < N; k++) begin
                    longint acc;
                    hist[k].push_back(bus.in_data[32*k +: 32]);
                    if (hist[k].size() > DEPTH) void'(hist[k].pop_front());
                    acc = 0;
                    foreach (hist[k][i]) acc += longint'(hist[k][i]);
                    m_sum[k] = fit(acc);
                end
                if (m_cnt < DEPTH) m_cnt++;
                m_warm = (m_cnt == DEPTH);
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [N*32-1:0] exp_sum;
            for (int k = 0; k < N; k++) exp_sum[32*k +: 32] = m_sum[k];
            check("warm", bus.warm, m_warm);
            check("active", bus.active, m_active);
            check("divert_src", bus.divert_src, m_src_oh);
            check("divert_dst", bus.divert_dst, m_dst_oh);
            check("sum_out", bus.sum_out, exp_sum);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic r, input logic v, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] d3, input logic [31:0] th);
        rst           = r;
        bus.in_valid  = v;
        bus.in_data   = {d3, d2, d1, d0};
        bus.threshold = th;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int seen;
        int hot;
        logic [31:0] th;
        logic [31:0] d [4];

        rst = 1'b1; bus.in_valid = 1'b0; bus.in_data = '0; bus.threshold = '0;
        cyc(1, 0, 0, 0, 0, 0, 0);
        cmp_en = 1'b1;
        check("rst_active", bus.active, 0);
        check("rst_warm", bus.warm, 0);
        check("rst_src_dst", {bus.divert_src, bus.divert_dst}, 0);
        check("rst_sum", bus.sum_out, 0);

        // warm-up with all-ones
        for (int i = 0; i < 7; i++) cyc(0, 1, 1, 1, 1, 1, 100);
        check("warm_after7", bus.warm, 0);
        check("active_after7", bus.active, 0);
        cyc(0, 1, 1, 1, 1, 1, 100);
        check("warm_after8", bus.warm, 1);
        check("sum_after8", bus.sum_out, {4{32'd8}});
        check("model_sum_after8", m_sum[2], 32'd8);

        // {5,1,1,1}: entry 3 cycles after the 8th strobe
        cyc(1, 0, 0, 0, 0, 0, 20);
        for (int i = 0; i < 8; i++) cyc(0, 1, 5, 1, 1, 1, 20);
        check("sum_5111", bus.sum_out, {32'd8, 32'd8, 32'd8, 32'd40});
        cyc(0, 0, 0, 0, 0, 0, 20);
        check("active_lat1", bus.active, 0);
        cyc(0, 0, 0, 0, 0, 0, 20);
        check("active_lat2", bus.active, 0);
        cyc(0, 0, 0, 0, 0, 0, 20);
        check("active_lat3", bus.active, 1);
        check("model_active_lat3", m_active, 1);
        check("src_5111", bus.divert_src, 4'b0001);
        check("dst_5111", bus.divert_dst, 4'b0010);

        // drop to ones: hold, then exit with an IDLE gap
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 1, 1, 1, 1, 20);
            check("hold_active", bus.active, 1);
        end
        n = 0;
        while (bus.active && n < 30) begin
            cyc(0, 1, 1, 1, 1, 1, 20);
            n++;
        end
        check("exit_seen", bus.active, 0);
        cyc(0, 1, 1, 1, 1, 1, 20);
        check("idle_gap", bus.active, 0);

        // channel 3 becomes busiest while diverting from channel 0
        cyc(1, 0, 0, 0, 0, 0, 20);
        for (int i = 0; i < 8; i++) cyc(0, 1, 5, 1, 1, 1, 20);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(0, 1, 1, 1, 1, 9, 20);
            if (bus.active) begin
                seen = 1;
                check("src_latched", bus.divert_src, 4'b0001);
            end else if (seen != 0) begin
                break;
            end
        end
        check("first_episode_ended", {seen[0], bus.active}, 2'b10);
        n = 0;
        while (!bus.active && n < 30) begin
            cyc(0, 1, 1, 1, 1, 9, 20);
            n++;
        end
        check("reentry_src", bus.divert_src, 4'b1000);

        // reset mid-DIVERT together with in_valid
        cyc(1, 1, 7, 7, 7, 7, 20);
        check("midrst_outputs", {bus.active, bus.warm, bus.divert_src, bus.divert_dst}, 0);
        check("midrst_sum", bus.sum_out, 0);
        cyc(0, 0, 0, 0, 0, 0, 20);
        check("midrst_no_sample", bus.sum_out, 0);

        // overflow on channel 0
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) cyc(0, 1, 32'h4000_0000, 0, 0, 0, 0);
        check("ovf_after2", bus.sum_out[31:0], EXP_OVF2);
        for (int i = 0; i < 6; i++) cyc(0, 1, 32'h4000_0000, 0, 0, 0, 0);
        check("ovf_after8", bus.sum_out[31:0], EXP_OVF8);
        for (int i = 0; i < 7; i++) cyc(0, 1, 0, 0, 0, 0, 0);
        check("ovf_decay", bus.sum_out[31:0], 32'h4000_0000);

        // randomized traffic
        hot = 0;
        th  = 32'd10;
        for (int c = 0; c < 3000; c++) begin
            if (c % 50 == 0) hot = int'($urandom_range(0, 3));
            if (c % 64 == 0) th = $urandom_range(0, 60) - 32'd10;
            for (int k = 0; k < 4; k++) begin
                d[k] = (k == hot) ? $urandom_range(0, 12) : $urandom_range(0, 4);
                if ($urandom_range(0, 63) == 0) d[k] = $urandom;
            end
            cyc($urandom_range(0, 399) == 0, $urandom_range(0, 3) != 0,
                d[0], d[1], d[2], d[3], th);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/balancer_n.md
Name: balancer_n

Overview:
- N-channel, parametrised successor to the two-channel balancer.
- Each channel's per-sample item count is summed over a rolling window of DEPTH samples.
- The busiest and idlest channels are identified. A hysteresis state machine raises a latched one-hot divert request from the busiest channel to the idlest.
- Sits between belt-sensor inputs and inserter/filter control outputs in the factory logistics layer.

Parameters:
- N, 4, number of channels (2..16)
- DEPTH, 8, rolling window length in samples (power of two, 2..64)
- HOLD, 4, minimum cycles DIVERT stays asserted once entered (>=1)
- HYST, 2, hysteresis subtracted from threshold for the exit condition

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, synchronous, active-high
- in_valid  in  1  strobe: in_data holds one new sample per channel
- in_data  in  N*32  signed samples, channel k at bits [32k+31:32k]
- threshold  in  32  signed imbalance threshold, sampled every cycle
- warm  out  1  window filled; DEPTH samples accepted since reset
- active  out  1  high while in DIVERT
- divert_src  out  N  one-hot source channel (busiest), 0 when not active
- divert_dst  out  N  one-hot destination channel (idlest), 0 when not active
- sum_out  out  N*32  registered window sums, channel k at bits [32k+31:32k]

Behaviour:
- Reset: every output is 0. Ring buffers, sums, pointer, fill counter and FSM are cleared. Reset wins over in_valid in the same cycle. Reset mid-DIVERT drops to IDLE next cycle and forces warm=0.
- Window: per channel, a DEPTH-entry ring buffer plus a running sum.
  - On in_valid: sum <= sum + new - oldest; oldest slot <= new.
  - The pointer is shared across channels and wraps DEPTH-1 -> 0.
  - Without in_valid, nothing changes.
- Arithmetic: 32-bit signed two's-complement. Wrap on overflow (see Optional Feature).
- Warm-up: the fill counter saturates at DEPTH; warm=1 once it reaches DEPTH. Before that the FSM is held in IDLE.
- Pipeline:
  - Stage 1 is sum_out, updated the cycle after in_valid.
  - Stage 2 registers max_idx, min_idx, max_sum, min_sum.
  - Tie-break: lowest index wins for both max and min. When all sums are equal, max_idx = min_idx = 0.
  - FSM decisions use stage-2 values. Total latency from the in_valid edge to an active change is 3 cycles.
- FSM states: IDLE, DIVERT.
  - IDLE -> DIVERT when warm && max_idx != min_idx && max_sum > min_sum + threshold. On entry, latch src=max_idx, dst=min_idx and load the hold counter with HOLD.
  - DIVERT: src and dst stay latched; later max/min changes are ignored. The hold counter decrements every cycle down to 0.
  - DIVERT -> IDLE when hold==0 && sum[src] <= sum[dst] + threshold - HYST, using current stage-1 sums of the latched channels.
  - Exit and re-entry cannot occur in the same cycle; there is at least one IDLE cycle between them.
- Outputs: active = (state==DIVERT). divert_src = active ? 1<<src : 0. divert_dst = active ? 1<<dst : 0. All outputs are registered.

Optional Feature:
- Macro: BALANCER_N_SATURATE_EN.
- Defined: running-sum update and threshold additions saturate to 32'h7FFFFFFF / 32'h80000000 instead of wrapping.
  - Ring buffer contents stay exact.
  - The running sum is recomputed as the saturated sum of all entries whenever an intermediate result saturates, so it recovers when values return in range.
- Undefined: pure wrap-around arithmetic, as in the base balancer.

Decomposition:
- Shared package balancer_pkg:
  - SAMPLE_W=32
  - state encoding (IDLE=0, DIVERT=1)
  - function onehot(idx, N)
  - function sat_add32 (used only under the macro)
- Sub-module rolling_window_sum:
  - parameters DEPTH and SAMPLE_W
  - ports clk, rst, in_valid, wr_ptr, sample, sum
  - instantiated N times, with the pointer and fill counter kept in the parent.

Test Plan:
- N=4, DEPTH=8: reset, then 7 strobes of all-ones -> warm=0, active=0. 8th strobe -> warm=1 and sum_out = 8 per channel.
- Channels {5,1,1,1} per sample, threshold=20, after warm-up -> sums {40,8,8,8}; active=1 exactly 3 cycles after the 8th strobe; divert_src=4'b0001, divert_dst=4'b0010 (tie -> lowest index).
- Inputs then drop to {1,1,1,1}, HOLD=4, HYST=2 -> active holds at least 4 cycles. It falls the cycle after hold==0 once sum[0] <= sum[1]+18, with at least one IDLE cycle before any re-entry.
- While in DIVERT, channel 3 becomes busiest -> divert_src stays 4'b0001 until exit.
- rst pulsed mid-DIVERT alongside in_valid -> the next cycle has all outputs 0 and warm=0, and no sample is accepted.
- Channel 0 fed 32'h40000000 for 8 samples -> the sum wraps when the macro is undefined. With BALANCER_N_SATURATE_EN, sum_out[0] = 32'h7FFFFFFF; feeding zeros afterwards decays it exactly.
